seq_bin_to_bcd: RTL

- Iterative (double-dabble) binary-to-BCD converter.
- Sits between the vending machine money register and the seven-segment driver, replacing the combinational converter on that path.
- Accepts a start pulse, converts the BIN_W-bit credit value over BIN_W shift cycles, then presents registered BCD digits with a one-cycle done pulse.
- Outputs hold the last result, so the display stays stable during a conversion.

---
 rtl/seq_bin_to_bcd_pkg.sv | 21 ++
 rtl/seq_bin_to_bcd_add3_cell.sv | 10 +
 rtl/seq_bin_to_bcd.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seq_bin_to_bcd_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter and the display path.
// State encoding, blank digit code and default widths live here.
package seq_bin_to_bcd_pkg;

    localparam int DEFAULT_BIN_W  = 12;
    localparam int DEFAULT_DIGITS = 4;

    // Seven-segment driver treats this nibble as "segment off".
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int iterations);
        return $clog2(iterations + 1);
    endfunction

endpackage

// File: rtl/seq_bin_to_bcd_add3_cell.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
// Purely combinational, one instance per BCD digit.
module bcd_add3_cell (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Iterative double-dabble converter: one shift per cycle, registered BCD held between runs.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits (never digit 0) with BCD_BLANK.
module seq_bin_to_bcd
    import seq_bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = DEFAULT_BIN_W,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [BIN_W-1:0]   shift_reg, shift_next;
    logic [SCR_W-1:0]   scratch_reg, scratch_next;
    logic [SCR_W-1:0]   bcd_reg, bcd_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [SCR_W-1:0]       corr;
    logic [SCR_W+BIN_W-1:0] shifted;
    logic [SCR_W-1:0]       shifted_scratch;
    logic [SCR_W-1:0]       final_bcd;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_cell
            bcd_add3_cell u_cell (
                .digit (scratch_reg[4*gi +: 4]),
                .fixed (corr[4*gi +: 4])
            );
        end
    endgenerate

    // The corrected scratch can never carry into a bit above SCR_W, so the plain shift is exact.
    assign shifted         = {corr, shift_reg} << 1;
    assign shifted_scratch = shifted[SCR_W+BIN_W-1 -: SCR_W];

`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[k] is set when digits k..DIGITS-1 of the final result are all zero.
    logic [DIGITS:1] zero_from;
    assign zero_from[DIGITS] = 1'b1;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_ones
                assign final_bcd[3:0] = shifted_scratch[3:0];
            end else begin : g_upper
                if (gi < DIGITS) begin : g_chain
                    assign zero_from[gi] = zero_from[gi+1] && (shifted_scratch[4*gi +: 4] == 4'd0);
                end
                assign final_bcd[4*gi +: 4] = zero_from[gi] ? BCD_BLANK : shifted_scratch[4*gi +: 4];
            end
        end
    endgenerate
`else
    assign final_bcd = shifted_scratch;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        scratch_next = scratch_reg;
        bcd_next     = bcd_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    shift_next   = bin;
                    scratch_next = '0;
                    cnt_next     = CNT_W'(BIN_W);
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_next, shift_next} = shifted;
                cnt_next = cnt_reg - CNT_W'(1);
                // Load the result on the last shift so done and bcd appear together.
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                    bcd_next   = final_bcd;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            scratch_reg <= '0;
            bcd_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            scratch_reg <= scratch_next;
            bcd_reg     <= bcd_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule
